oam_dma: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 23 ++
 rtl/dma_bus_mux.sv | 14 +
 rtl/oam_dma.sv | 96 +++++++++
 tb/tb_oam_dma.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared definitions for masters on the NES system memory bus.
// Holds the DMA state encoding, fixed register addresses and the bus request struct.
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
  } bus_req_t;

endpackage

// File: rtl/dma_bus_mux.sv
// Combinational selector between the CPU and a DMA master on the shared bus.
// Any future DMA master (e.g. DMC) can reuse it with its own select.
module dma_bus_mux
  import nes_bus_pkg::*;
(
  input  logic     dma_sel,
  input  bus_req_t cpu_req,
  input  bus_req_t dma_req,
  output bus_req_t bus_req
);

  assign bus_req = dma_sel ? dma_req : cpu_req;

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to $4014 it halts the CPU and copies one 256-byte
// page to the OAM data port with alternating read/write bus cycles.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_TRIG_ADDR = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_mem_addr,
  input  logic [7:0]  cpu_mem_data_out,
  input  logic        cpu_mem_write_en,
  input  logic        cpu_mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic        halt,
  output logic        dma_active
);

  dma_state_t  state, state_nxt;
  logic        cyc_par;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic        trig;
  bus_req_t    cpu_req, dma_req, bus_req;

  assign trig = cpu_mem_write_en && (cpu_mem_addr == DMA_TRIG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc_par <= 1'b0;
      page    <= 8'h00;
      idx     <= 8'h00;
    end else begin
      state   <= state_nxt;
      cyc_par <= ~cyc_par;
      if (state == IDLE && trig) begin
        page <= cpu_mem_data_out;
        idx  <= 8'h00;
      end else if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Next state and DMA-side bus request; CPU inputs only matter in IDLE.
  always_comb begin
    state_nxt     = state;
    dma_req       = '0;
    case (state)
      IDLE:  if (trig) state_nxt = HALT;
      HALT:  state_nxt = cyc_par ? ALIGN : READ;
      ALIGN: state_nxt = READ;
      READ: begin
        dma_req.addr = {page, idx};
        dma_req.re   = 1'b1;
        state_nxt    = WRITE;
      end
      WRITE: begin
        dma_req.addr  = OAM_DATA_ADDR;
        dma_req.wdata = mem_data_in;
        dma_req.we    = 1'b1;
        state_nxt     = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dma_active = (state != IDLE);
  assign halt       = dma_active;

  always_comb begin
    cpu_req.addr  = cpu_mem_addr;
    cpu_req.wdata = cpu_mem_data_out;
    cpu_req.we    = cpu_mem_write_en;
    cpu_req.re    = cpu_mem_read_en;
  end

  dma_bus_mux u_mux (
    .dma_sel (dma_active),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .bus_req (bus_req)
  );

  assign mem_addr     = bus_req.addr;
  assign mem_data_out = bus_req.wdata;
  assign mem_write_en = bus_req.we;
  assign mem_read_en  = bus_req.re;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected read addresses and OAM writes are queued
// at trigger time and popped as the DMA drives the bus.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_mem_addr = 16'h0000;
  logic [7:0]  cpu_mem_data_out = 8'h00;
  logic        cpu_mem_write_en = 1'b0;
  logic        cpu_mem_read_en = 1'b0;
  logic [7:0]  mem_data_in = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_write_en;
  logic        mem_read_en;
  logic        halt;
  logic        dma_active;

  int n_chk = 0;
  int n_fail = 0;
  logic tb_par;

  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_wr_q[$];

  oam_dma dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_mem_addr     (cpu_mem_addr),
    .cpu_mem_data_out (cpu_mem_data_out),
    .cpu_mem_write_en (cpu_mem_write_en),
    .cpu_mem_read_en  (cpu_mem_read_en),
    .mem_data_in      (mem_data_in),
    .mem_addr         (mem_addr),
    .mem_data_out     (mem_data_out),
    .mem_write_en     (mem_write_en),
    .mem_read_en      (mem_read_en),
    .halt             (halt),
    .dma_active       (dma_active)
  );

  always #5 clk = ~clk;

  // Reference parity counter, independent of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  // RAM model: one-cycle read latency, pattern data = addr[7:0] ^ 5A.
  always @(posedge clk) begin
    if (mem_read_en) mem_data_in <= mem_addr[7:0] ^ 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && dma_active) begin
      chk("halt_eq_active", halt, 1'b1);
      if (mem_read_en) begin
        chk("rd_we_clash", mem_write_en, 1'b0);
        if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", mem_addr, exp_rd_q.pop_front());
      end
      if (mem_write_en) begin
        chk("wr_addr", mem_addr, 16'h2004);
        if (exp_wr_q.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_data", mem_data_out, exp_wr_q.pop_front());
      end
    end
  end

  task automatic passthru(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
    @(negedge clk);
    cpu_mem_addr = a; cpu_mem_data_out = d; cpu_mem_write_en = we; cpu_mem_read_en = re;
    #1;
    chk("pt_active", dma_active, 1'b0);
    chk("pt_addr", mem_addr, a);
    chk("pt_data", mem_data_out, d);
    chk("pt_we", mem_write_en, we);
    chk("pt_re", mem_read_en, re);
  endtask

  // Trigger a transfer at the requested T0 parity; optionally retrigger or reset mid-way.
  task automatic run_dma(input logic [7:0] pg, input logic want_par, input bit retrig,
                         input bit rst_mid);
    int hcnt, idle, wrs, exp_h;
    bit aborted;
    logic [7:0] b;
    hcnt = 0; idle = 0; wrs = 0; aborted = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tb_par == want_par) break;
    end
    chk("t0_parity", tb_par, want_par);
    exp_h = tb_par ? 513 : 514;
    cpu_mem_addr = 16'h4014; cpu_mem_data_out = pg; cpu_mem_write_en = 1'b1; cpu_mem_read_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      exp_rd_q.push_back({pg, b});
      exp_wr_q.push_back(b ^ 8'h5A);
    end
    #1;
    chk("trig_on_bus", {mem_addr, mem_write_en, halt}, {16'h4014, 1'b1, 1'b0});
    @(posedge clk); #1;
    cpu_mem_write_en = 1'b0; cpu_mem_addr = 16'h0000;
    for (int c = 0; c < 700; c++) begin
      if (!halt) break;
      hcnt++;
      if (!mem_read_en && !mem_write_en) idle++;
      if (mem_write_en) wrs++;
      if (rst_mid && mem_write_en && wrs == 101) begin
        rst = 1'b1;
        cpu_mem_addr = 16'h1234; cpu_mem_data_out = 8'hAB; cpu_mem_read_en = 1'b1;
        #1;
        chk("rst_halt", halt, 1'b0);
        chk("rst_active", dma_active, 1'b0);
        chk("rst_bus", {mem_addr, mem_data_out, mem_read_en, mem_write_en},
            {16'h1234, 8'hAB, 1'b1, 1'b0});
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(negedge clk);
        rst = 1'b0; cpu_mem_read_en = 1'b0;
        aborted = 1;
        break;
      end
      if (retrig && wrs >= 50 && wrs < 54) begin
        cpu_mem_addr = 16'h4014; cpu_mem_data_out = 8'h77; cpu_mem_write_en = 1'b1;
      end else begin
        cpu_mem_write_en = 1'b0; cpu_mem_addr = 16'h0000;
      end
      @(posedge clk); #1;
    end
    cpu_mem_write_en = 1'b0;
    if (!aborted) begin
      chk("halt_cycles", hcnt, exp_h);
      chk("idle_cycles", idle, exp_h - 512);
      chk("write_count", wrs, 256);
      chk("rd_left", exp_rd_q.size(), 0);
      chk("wr_left", exp_wr_q.size(), 0);
      chk("end_active", dma_active, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_halt", halt, 1'b0);
    chk("reset_active", dma_active, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    passthru(16'h4015, 8'h0F, 1'b1, 1'b0);
    passthru(16'h2004, 8'hC3, 1'b1, 1'b0);
    passthru(16'h4014, 8'h00, 1'b0, 1'b1);
    passthru(16'hFFFF, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      logic w;
      a = 16'($urandom);
      w = 1'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      passthru(a, 8'($urandom), w, ~w);
    end
    passthru(16'h0000, 8'h00, 1'b0, 1'b0);

    run_dma(8'h02, 1'b1, 0, 0);
    run_dma(8'h03, 1'b0, 0, 0);
    run_dma(8'hFF, 1'b1, 0, 0);
    passthru(16'h0000, 8'h11, 1'b0, 1'b1);
    run_dma(8'h05, 1'b0, 0, 1);
    passthru(16'h0300, 8'h22, 1'b1, 1'b0);
    run_dma(8'h06, 1'b1, 0, 0);
    run_dma(8'h07, 1'b0, 1, 0);
    run_dma(8'h08, 1'b1, 1, 0);
    passthru(16'h4016, 8'h01, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
